mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Initiator-side controller for the 256x16 synchronous main memory. Owns the memory's we/addr/din pins and consumes its dout.
- Accepts load/fill requests from the execution unit over a valid/ready handshake.
- A read request returns a burst of consecutive words through a response stream with backpressure.
- A write request fills consecutive words with one value.

Parameters:
- AW, 8, address width; memory depth is 2^AW words.
- DW, 16, data width.
- LENW, 4, burst length field width; the burst length is req_len+1 words (1..16).

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = fill/write, 0 = read burst
- req_addr  input  AW  start address
- req_len  input  LENW  burst length minus one
- req_wdata  input  DW  fill value; ignored for reads
- rsp_valid  output  1  response word present
- rsp_ready  input  1  consumer accepts the response word
- rsp_data  output  DW  read data
- rsp_last  output  1  marks the final word of a read burst
- mem_we  output  1  to the memory write enable
- mem_addr  output  AW  to the memory address
- mem_din  output  DW  to the memory write data
- mem_dout  input  DW  from the memory; valid the cycle after the address is sampled
- busy  output  1  high whenever state != IDLE or the response FIFO is non-empty

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - req_ready = 1; rsp_valid = 0; rsp_last = 0; rsp_data = 0.
  - mem_we = 0; mem_addr = 0; mem_din = 0; busy = 0.
  - Response FIFO and in-flight flag cleared.
  - Reset mid-burst aborts the burst; in-flight read data is discarded.
- A request is accepted on the rising edge where req_valid && req_ready.
- req_ready = (state == IDLE) && FIFO empty && no read in flight. Requests therefore complete strictly in order, and a read that follows a fill observes the filled data.
- All mem_* outputs are registered.
- The address counter increments modulo 2^AW; a burst wraps through 0 (for example FE, FF, 00, 01).
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - On accept with req_we = 1: load addr/len/wdata into registers, go to WRITE.
  - On accept with req_we = 0: load addr/len, go to READ.
- WRITE:
  - mem_we = 1 and mem_din = wdata_q for exactly len+1 consecutive cycles, with the address incrementing each cycle.
  - After the last word: mem_we = 0, return to IDLE.
  - No response is generated for a write.
- READ issue rule:
  - A read is issued (the address is presented with mem_we = 0 and the memory samples it) only when (fifo_count + inflight - pop) < 2, where pop = rsp_valid && rsp_ready.
  - Data is captured from mem_dout into the 2-entry FIFO one edge after issue.
  - The FIFO entry carries a last flag.
  - After issuing word len+1, the FSM returns to IDLE; the FIFO drains afterwards.
- Latency: with the accept at edge 0, the memory samples the first address at edge 1 and rsp_valid rises after edge 2.
- Throughput: one word per cycle while rsp_ready stays high.
- Backpressure: with rsp_ready low, at most 2 words are buffered; no word is dropped or duplicated, and rsp_data/rsp_last hold stable while rsp_valid is high and rsp_ready is low.
- rsp_ready is ignored when rsp_valid = 0.
- req_* inputs are ignored when req_ready = 0.

Optional Feature:
- Macro MEM_CTRL_STATS_EN.
- When defined:
  - Adds output ports rd_count[15:0] and wr_count[15:0].
  - These count words read (on FIFO capture) and words written (mem_we cycles).
  - Both saturate at 16'hFFFF and reset to 0 on reset_n low.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Fill then read: fill addr 8'h10, len 3, wdata 16'hBEEF; then read addr 8'h10, len 3 with rsp_ready = 1. Expect exactly 4 writes at 10..13, then 4 responses of BEEF with rsp_last on the 4th, and the first rsp_valid 2 cycles after the read is accepted.
- Wrap-around: fill FE..01 with 16'h1234, then read addr 8'hFE, len 3. Expect mem_addr sequence FE, FF, 00, 01 and 4 words of 1234.
- Backpressure: read 16 words with rsp_ready toggling 1,0,0,1 repeatedly. Expect the data sequence to match the memory in order with no loss or duplicates, fifo occupancy never above 2, and rsp_data stable while stalled.
- Handshake: assert req_valid during an active burst. Expect req_ready = 0 and the request not accepted until busy = 0.
- Reset mid-operation: drop reset_n during the 3rd word of a 16-word fill. Expect mem_we = 0 immediately, the remaining words unwritten, req_ready = 1, and busy = 0.
- Stats (MEM_CTRL_STATS_EN): after the first scenario, expect wr_count = 4 and rd_count = 4.

Source files
------------

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_ctrl_if : request/response stream and memory pin bundle          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface mem_ctrl_if #(
  parameter int AW   = 8,
  parameter int DW   = 16,
  parameter int LENW = 4
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [LENW-1:0] req_len;
  logic [DW-1:0]   req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din;
  logic [DW-1:0]   mem_dout;

  // Environment side: execution unit plus the memory array.
  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata, rsp_ready, mem_dout,
    input  req_ready, rsp_valid, rsp_data, rsp_last, mem_we, mem_addr, mem_din
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata, rsp_ready, mem_dout,
    output req_ready, rsp_valid, rsp_data, rsp_last, mem_we, mem_addr, mem_din
  );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_ctrl : burst read / fill controller for a synchronous memory     |
// | Optional : MEM_CTRL_STATS_EN adds saturating rd_count / wr_count     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mem_ctrl #(
  parameter int AW   = 8,
  parameter int DW   = 16,
  parameter int LENW = 4
) (
  input  wire         clk,
  input  wire         reset_n,
  mem_ctrl_if.slave   bus,
  output logic        busy
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [DW-1:0]       mem_din_q, mem_din_d;
  logic                mem_we_q, mem_we_d;
  logic [LENW-1:0]     cnt_q, cnt_d;
  logic                inflight_q, inflight_d;
  logic                infl_last_q, infl_last_d;
  logic [1:0][DW:0]    fifo_q, fifo_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;

  logic                w_pop;
  logic                w_push;
  logic                w_accept;
  logic [2:0]          w_occ;
  logic                w_issue;

  assign bus.req_ready = (state_q == IDLE) && (count_q == 2'd0) && !inflight_q;
  assign bus.rsp_valid = (count_q != 2'd0);
  assign bus.rsp_data  = fifo_q[rd_ptr_q][DW-1:0];
  assign bus.rsp_last  = bus.rsp_valid && fifo_q[rd_ptr_q][DW];
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign busy          = (state_q != IDLE) || (count_q != 2'd0);

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = 1'b0;
    cnt_d       = cnt_q;
    inflight_d  = 1'b0;
    infl_last_d = 1'b0;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    w_pop    = bus.rsp_valid && bus.rsp_ready;
    w_push   = inflight_q;
    w_accept = bus.req_valid && bus.req_ready;
    // Words already buffered or on their way, after this edge's pop.
    w_occ    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    w_issue  = (state_q == READ) && (w_occ < 3'd2);

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          mem_addr_d = bus.req_addr;
          cnt_d      = bus.req_len;
          if (bus.req_we) begin
            mem_we_d  = 1'b1;
            mem_din_d = bus.req_wdata;
            state_d   = WRITE;
          end else begin
            state_d   = READ;
          end
        end
      end
      WRITE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = mem_addr_q + AW'(1);
          cnt_d      = cnt_q - LENW'(1);
        end
      end
      READ: begin
        // The memory samples mem_addr_q at this edge; its data returns next edge.
        if (w_issue) begin
          inflight_d  = 1'b1;
          infl_last_d = (cnt_q == '0);
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            mem_addr_d = mem_addr_q + AW'(1);
            cnt_d      = cnt_q - LENW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_push) begin
      fifo_d[wr_ptr_q] = {infl_last_q, bus.mem_dout};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      fifo_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

`ifdef MEM_CTRL_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (inflight_q && (rd_count_q != 16'hFFFF)) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if (mem_we_q && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_ctrl : directed self-checking bench for mem_ctrl              |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_mem_ctrl;
  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int LENW = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_ctrl_if #(.AW(AW), .DW(DW), .LENW(LENW)) bus ();

`ifdef MEM_CTRL_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  mem_ctrl #(.AW(AW), .DW(DW), .LENW(LENW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
`ifdef MEM_CTRL_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  // Synchronous 256x16 memory, read-before-write.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  // Append-only logs of memory writes and accepted responses.
  logic [AW-1:0] wa_log [$];
  logic [DW-1:0] wd_log [$];
  logic [DW-1:0] rd_log [$];
  logic          rl_log [$];
  int            stall_viol = 0;
  int            occ_viol = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (bus.mem_we) begin
        wa_log.push_back(bus.mem_addr);
        wd_log.push_back(bus.mem_din);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rd_log.push_back(bus.rsp_data);
        rl_log.push_back(bus.rsp_last);
      end
      if (prev_stall && (bus.rsp_valid !== 1'b1 || bus.rsp_data !== prev_data)) stall_viol++;
      if (dut.count_q > 2'd2) occ_viol++;
      prev_stall = bus.rsp_valid && !bus.rsp_ready;
      prev_data  = bus.rsp_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_req(input logic we, input logic [AW-1:0] addr,
                          input logic [LENW-1:0] len, input logic [DW-1:0] wdata);
    int guard;
    guard = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_wdata = wdata;
    while (bus.req_ready !== 1'b1 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: req_ready=%b required 1", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(busy === 1'b0 && bus.req_ready === 1'b1) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_last !== 1'b0) begin errors++; $display("FAIL reset_rsp_last: got %b want 0", bus.rsp_last); end
    checks++; if (bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data: got %h want 0000", bus.rsp_data); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h want 00", bus.mem_addr); end
    checks++; if (bus.mem_din !== 16'h0000) begin errors++; $display("FAIL reset_mem_din: got %h want 0000", bus.mem_din); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef MEM_CTRL_STATS_EN
    checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin errors++; $display("FAIL reset_stats: got rd=%0d wr=%0d want 0 0", rd_count, wr_count); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_read();
    int b, rb;
    b = wa_log.size();
    send_req(1'b1, 8'h10, 4'd3, 16'hBEEF);
    wait_idle();
    checks++; if (wa_log.size() - b !== 4) begin errors++; $display("FAIL fill_count: got %0d want 4", wa_log.size() - b); end
    for (int i = 0; i < 4; i++) begin
      if (b + i < wa_log.size()) begin
        checks++;
        if (wa_log[b+i] !== 8'(8'h10 + i) || wd_log[b+i] !== 16'hBEEF) begin
          errors++; $display("FAIL fill_word%0d: got %h:%h want %h:beef", i, wa_log[b+i], wd_log[b+i], 8'(8'h10 + i));
        end
      end
    end
    rb = rd_log.size();
    bus.rsp_ready = 1'b1;
    send_req(1'b0, 8'h10, 4'd3, 16'h0000);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_edge0: rsp_valid got %b want 0", bus.rsp_valid); end
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_edge1: rsp_valid got %b want 0", bus.rsp_valid); end
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hBEEF) begin errors++; $display("FAIL lat_edge2: got %b/%h want 1/beef", bus.rsp_valid, bus.rsp_data); end
    wait_idle();
    checks++; if (rd_log.size() - rb !== 4) begin errors++; $display("FAIL read_count: got %0d want 4", rd_log.size() - rb); end
    for (int i = 0; i < 4; i++) begin
      if (rb + i < rd_log.size()) begin
        checks++;
        if (rd_log[rb+i] !== 16'hBEEF || rl_log[rb+i] !== (i == 3)) begin
          errors++; $display("FAIL read_word%0d: got %h last=%b want beef last=%b", i, rd_log[rb+i], rl_log[rb+i], (i == 3));
        end
      end
    end
`ifdef MEM_CTRL_STATS_EN
    checks++; if (wr_count !== 16'd4 || rd_count !== 16'd4) begin errors++; $display("FAIL stats: got rd=%0d wr=%0d want 4 4", rd_count, wr_count); end
`endif
  endtask

  task automatic test_wrap();
    int b, rb;
    logic [AW-1:0] ea;
    b = wa_log.size();
    send_req(1'b1, 8'hFE, 4'd3, 16'h1234);
    wait_idle();
    checks++; if (wa_log.size() - b !== 4) begin errors++; $display("FAIL wrap_fill_count: got %0d want 4", wa_log.size() - b); end
    for (int i = 0; i < 4; i++) begin
      ea = 8'hFE + 8'(i);
      if (b + i < wa_log.size()) begin
        checks++;
        if (wa_log[b+i] !== ea) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, wa_log[b+i], ea); end
      end
    end
    rb = rd_log.size();
    bus.rsp_ready = 1'b1;
    send_req(1'b0, 8'hFE, 4'd3, 16'h0000);
    wait_idle();
    checks++; if (rd_log.size() - rb !== 4) begin errors++; $display("FAIL wrap_read_count: got %0d want 4", rd_log.size() - rb); end
    for (int i = 0; i < 4; i++) begin
      if (rb + i < rd_log.size()) begin
        checks++;
        if (rd_log[rb+i] !== 16'h1234 || rl_log[rb+i] !== (i == 3)) begin
          errors++; $display("FAIL wrap_word%0d: got %h last=%b want 1234 last=%b", i, rd_log[rb+i], rl_log[rb+i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int rb, sv, ov, k, guard;
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < 16; i++) begin
      send_req(1'b1, 8'(8'h20 + i), 4'd0, 16'(16'h5A00 + i));
      wait_idle();
    end
    rb = rd_log.size();
    sv = stall_viol;
    ov = occ_viol;
    bus.rsp_ready = 1'b1;
    send_req(1'b0, 8'h20, 4'd15, 16'h0000);
    k = 0;
    guard = 0;
    while (rd_log.size() - rb < 16 && guard < 400) begin
      bus.rsp_ready = pat[k % 4];
      @(posedge clk); #1;
      k++;
      guard++;
    end
    bus.rsp_ready = 1'b1;
    wait_idle();
    checks++; if (rd_log.size() - rb !== 16) begin errors++; $display("FAIL bp_count: got %0d want 16", rd_log.size() - rb); end
    for (int i = 0; i < 16; i++) begin
      if (rb + i < rd_log.size()) begin
        checks++;
        if (rd_log[rb+i] !== 16'(16'h5A00 + i) || rl_log[rb+i] !== (i == 15)) begin
          errors++; $display("FAIL bp_word%0d: got %h last=%b want %h last=%b", i, rd_log[rb+i], rl_log[rb+i], 16'(16'h5A00 + i), (i == 15));
        end
      end
    end
    checks++; if (stall_viol - sv !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_viol - sv); end
    checks++; if (occ_viol - ov !== 0) begin errors++; $display("FAIL bp_occupancy: got %0d overflows want 0", occ_viol - ov); end
  endtask

  task automatic test_handshake();
    int b, rb, waited, busy_viol;
    b = wa_log.size();
    bus.rsp_ready = 1'b1;
    send_req(1'b1, 8'h40, 4'd15, 16'h7777);
    rb = rd_log.size();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h40;
    bus.req_len   = 4'd0;
    bus.req_wdata = 16'hFFFF;
    waited = 0;
    busy_viol = 0;
    while (bus.req_ready !== 1'b1 && waited < 300) begin
      if (busy !== 1'b1) busy_viol++;
      @(posedge clk); #1;
      waited++;
    end
    checks++; if (waited !== 16) begin errors++; $display("FAIL hs_wait: req_ready low for %0d cycles want 16", waited); end
    checks++; if (busy_viol !== 0) begin errors++; $display("FAIL hs_busy: busy low %0d times while not ready want 0", busy_viol); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_busy_at_ready: got %b want 0", busy); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_idle();
    checks++; if (wa_log.size() - b !== 16) begin errors++; $display("FAIL hs_fill_count: got %0d want 16", wa_log.size() - b); end
    checks++;
    if (rd_log.size() - rb !== 1) begin
      errors++; $display("FAIL hs_read_count: got %0d want 1", rd_log.size() - rb);
    end else if (rd_log[rb] !== 16'h7777 || rl_log[rb] !== 1'b1) begin
      errors++; $display("FAIL hs_read_data: got %h last=%b want 7777 last=1", rd_log[rb], rl_log[rb]);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    b = wa_log.size();
    send_req(1'b1, 8'h80, 4'd15, 16'hDEAD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h82) begin errors++; $display("FAIL rm_third_word: got we=%b addr=%h want 1 82", bus.mem_we, bus.mem_addr); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rm_we_async: got %b want 0", bus.mem_we); end
    checks++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rm_idle_async: ready=%b busy=%b want 1 0", bus.req_ready, busy); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wa_log.size() - b !== 2) begin errors++; $display("FAIL rm_words_written: got %0d want 2", wa_log.size() - b); end
    checks++; if (bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rm_after: ready=%b busy=%b we=%b want 1 0 0", bus.req_ready, busy, bus.mem_we); end
`ifdef MEM_CTRL_STATS_EN
    checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin errors++; $display("FAIL rm_stats: got rd=%0d wr=%0d want 0 0", rd_count, wr_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_wrap();
    test_backpressure();
    test_handshake();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
